// File: rtl/shr_pkg.sv
// Shared types and constants for the serial shift-register frame receiver.
package shr_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2
  } shr_state_e;

  localparam int N_BITS_DEF  = 620;
  localparam int SYNC_STAGES = 2;

  // Counter width able to hold the value n itself.
  function automatic int cnt_w_for(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shr_frame_rx_if.sv
// Serial GPIO lines towards the receiver and the captured-frame status back out.
interface shr_frame_rx_if
  import shr_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int CNT_W  = cnt_w_for(N_BITS_DEF)
);
  logic              ser_clk;
  logic              ser_din;
  logic              ser_syn;
  logic [N_BITS-1:0] data_reg;
  logic              frame_valid;
  logic              err_short;
  logic              err_long;
  logic              err_timeout;
  logic              busy;
  logic [CNT_W-1:0]  bit_cnt;
  logic [15:0]       frame_cnt;

  modport master (
    output ser_clk, ser_din, ser_syn,
    input  data_reg, frame_valid, err_short, err_long, err_timeout, busy, bit_cnt, frame_cnt
  );

  modport slave (
    input  ser_clk, ser_din, ser_syn,
    output data_reg, frame_valid, err_short, err_long, err_timeout, busy, bit_cnt, frame_cnt
  );
endinterface

// File: rtl/shr_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with optional rising-edge detect.
module shr_sync_edge
  import shr_pkg::*;
#(
  parameter bit RISE_EN = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchroniser chain plus one trailing stage used only for edge detection.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = RISE_EN ? (r_sync[SYNC_STAGES-1] & ~r_prev) : 1'b0;
endmodule

// File: rtl/shr_frame_rx.sv
// Oversampling receiver for the DIN/CLK/SYNC loader: rebuilds an N_BITS frame,
// checks its framing and publishes good frames.
module shr_frame_rx
  import shr_pkg::*;
#(
  parameter int N_BITS         = N_BITS_DEF,
  parameter bit SYN_ACTIVE_LOW = 1'b1,
  parameter int TIMEOUT_CYC    = 1_000_000,
  parameter int CNT_W          = cnt_w_for(N_BITS_DEF)
) (
  input logic          clk_in,
  input logic          rst,
  shr_frame_rx_if.slave rx
);
  localparam int               TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  shr_state_e        r_state, w_state_nxt;
  logic [N_BITS-1:0] r_sr, w_sr_nxt;
  logic [N_BITS-1:0] r_data, w_data_nxt;
  logic              r_fv, w_fv_nxt;
  logic              r_err_short, w_err_short_nxt;
  logic              r_err_long, w_err_long_nxt;
  logic              r_err_timeout, w_err_timeout_nxt;
  logic              r_busy;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [15:0]       r_frame_cnt, w_frame_cnt_nxt;
  logic [TO_W-1:0]   r_to_cnt, w_to_nxt;

  logic w_clk_s, w_edge, w_din, w_syn_s, w_syn_act, w_long_hit;

  // Sync reset level of ser_syn is its inactive level so reset never opens a frame.
  shr_sync_edge #(.RISE_EN(1'b1), .RST_VAL(1'b0)) u_sync_clk (
    .clk_in(clk_in), .rst(rst), .i_async(rx.ser_clk), .o_sync(w_clk_s), .o_rise(w_edge)
  );
  shr_sync_edge #(.RISE_EN(1'b0), .RST_VAL(1'b0)) u_sync_din (
    .clk_in(clk_in), .rst(rst), .i_async(rx.ser_din), .o_sync(w_din), .o_rise()
  );
  shr_sync_edge #(.RISE_EN(1'b0), .RST_VAL(SYN_ACTIVE_LOW)) u_sync_syn (
    .clk_in(clk_in), .rst(rst), .i_async(rx.ser_syn), .o_sync(w_syn_s), .o_rise()
  );

  assign w_syn_act  = SYN_ACTIVE_LOW ? ~w_syn_s : w_syn_s;
  assign w_long_hit = w_edge & (r_bit_cnt == CNT_FULL);

  // Next-state and datapath decode; an edge is applied before end-of-frame is judged.
  always_comb begin
    w_state_nxt       = r_state;
    w_sr_nxt          = r_sr;
    w_data_nxt        = r_data;
    w_fv_nxt          = 1'b0;
    w_err_short_nxt   = r_err_short;
    w_err_long_nxt    = r_err_long;
    w_err_timeout_nxt = r_err_timeout;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_frame_cnt_nxt   = r_frame_cnt;
    w_to_nxt          = r_to_cnt;
    case (r_state)
      IDLE: begin
        if (w_syn_act) begin
          w_state_nxt       = SHIFT;
          w_sr_nxt          = '0;
          w_bit_cnt_nxt     = '0;
          w_to_nxt          = '0;
          w_err_short_nxt   = 1'b0;
          w_err_long_nxt    = 1'b0;
          w_err_timeout_nxt = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (w_edge) begin
          w_to_nxt = '0;
          if (w_long_hit) begin
            w_err_long_nxt = 1'b1;
            w_state_nxt    = WAIT_END;
          end else begin
            w_sr_nxt      = {r_sr[N_BITS-2:0], w_din};
            w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
          end
        end else begin
          w_to_nxt = r_to_cnt + TO_ONE;
        end
        if (!w_syn_act) begin
          w_state_nxt = IDLE;
          if (w_long_hit) begin
            w_err_long_nxt = 1'b1;
          end else if (w_bit_cnt_nxt == CNT_FULL) begin
            w_data_nxt      = w_sr_nxt;
            w_fv_nxt        = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + 16'd1;
          end else begin
            w_err_short_nxt = 1'b1;
          end
        end else if (!w_edge && (r_to_cnt == TO_LAST)) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = WAIT_END;
        end else begin
          w_err_timeout_nxt = r_err_timeout;
        end
      end
      WAIT_END: begin
        if (!w_syn_act) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_END;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sr          <= '0;
      r_data        <= '0;
      r_fv          <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_busy        <= 1'b0;
      r_bit_cnt     <= '0;
      r_frame_cnt   <= 16'd0;
      r_to_cnt      <= '0;
    end else begin
      r_sr          <= w_sr_nxt;
      r_data        <= w_data_nxt;
      r_fv          <= w_fv_nxt;
      r_err_short   <= w_err_short_nxt;
      r_err_long    <= w_err_long_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      r_busy        <= (w_state_nxt != IDLE);
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_to_cnt      <= w_to_nxt;
    end
  end

  assign rx.data_reg    = r_data;
  assign rx.frame_valid = r_fv;
  assign rx.err_short   = r_err_short;
  assign rx.err_long    = r_err_long;
  assign rx.err_timeout = r_err_timeout;
  assign rx.busy        = r_busy;
  assign rx.bit_cnt     = r_bit_cnt;
  assign rx.frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_shr_frame_rx.sv
// Directed bench for shr_frame_rx: a queue-based frame model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_shr_frame_rx;
  localparam int N  = 620;
  localparam int CW = 10;
  localparam int TO = 100;
  localparam int M_IDLE = 0, M_RX = 1, M_DRAIN = 2;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   fv_seen  = 0;

  shr_frame_rx_if #(.N_BITS(N), .CNT_W(CW)) rx_if ();

  shr_frame_rx #(.N_BITS(N), .SYN_ACTIVE_LOW(1'b1), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst(rst), .rx(rx_if)
  );

  always #5 clk_in = ~clk_in;

  // Model state: received bits, published word, flags, and the 3-cycle input delay.
  logic [N-1:0] m_data;
  logic [15:0]  m_fcnt;
  bit           m_fv, m_es, m_el, m_et;
  bit           q[$];
  int           m_mode, m_run;
  bit           hc1, hc2, hc3, hd1, hd2, hs1, hs2;

  task automatic model_step();
    bit edge_s, act, long_s;
    if (rst) begin
      m_data = '0; m_fcnt = 16'd0; m_fv = 0; m_es = 0; m_el = 0; m_et = 0;
      q.delete(); m_mode = M_IDLE; m_run = 0;
      hc1 = 0; hc2 = 0; hc3 = 0; hd1 = 0; hd2 = 0; hs1 = 1; hs2 = 1;
    end else begin
      edge_s = hc2 && !hc3;
      act    = !hs2;
      long_s = 0;
      m_fv   = 0;
      case (m_mode)
        M_IDLE: begin
          if (act) begin
            m_mode = M_RX; q.delete(); m_run = 0; m_es = 0; m_el = 0; m_et = 0;
          end
        end
        M_RX: begin
          if (edge_s) begin
            m_run = 0;
            if (q.size() < N) q.push_back(hd2);
            else begin long_s = 1; m_el = 1; m_mode = M_DRAIN; end
          end else begin
            m_run++;
          end
          if (!act) begin
            m_mode = M_IDLE;
            if (!long_s) begin
              if (q.size() == N) begin
                for (int i = 0; i < N; i++) m_data[N-1-i] = q[i];
                m_fv = 1;
                m_fcnt = m_fcnt + 16'd1;
              end else begin
                m_es = 1;
              end
            end
          end else if (!edge_s && m_run == TO) begin
            m_et = 1; m_mode = M_DRAIN;
          end
        end
        default: begin
          if (!act) m_mode = M_IDLE;
        end
      endcase
      hc3 = hc2; hc2 = hc1; hc1 = rx_if.ser_clk;
      hd2 = hd1; hd1 = rx_if.ser_din;
      hs2 = hs1; hs1 = rx_if.ser_syn;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [CW-1:0] exp_cnt;
    bit            exp_busy;
    forever begin
      @(posedge clk_in);
      model_step();
      @(negedge clk_in);
      exp_cnt  = CW'(q.size());
      exp_busy = (m_mode != M_IDLE);
      n_checks++;
      if (rx_if.data_reg !== m_data) begin
        n_errors++;
        $display("FAIL data_reg @%0t: got %h want %h", $time, rx_if.data_reg, m_data);
      end
      n_checks++;
      if ({rx_if.frame_valid, rx_if.err_short, rx_if.err_long, rx_if.err_timeout, rx_if.busy,
           rx_if.bit_cnt, rx_if.frame_cnt} !==
          {m_fv, m_es, m_el, m_et, exp_busy, exp_cnt, m_fcnt}) begin
        n_errors++;
        $display("FAIL status @%0t: got fv=%b es=%b el=%b et=%b busy=%b cnt=%0d fcnt=%0d want fv=%b es=%b el=%b et=%b busy=%b cnt=%0d fcnt=%0d",
                 $time, rx_if.frame_valid, rx_if.err_short, rx_if.err_long, rx_if.err_timeout,
                 rx_if.busy, rx_if.bit_cnt, rx_if.frame_cnt,
                 m_fv, m_es, m_el, m_et, exp_busy, exp_cnt, m_fcnt);
      end
      if (rx_if.frame_valid) fv_seen++;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic syn_set(input bit active);
    @(negedge clk_in);
    rx_if.ser_syn = active ? 1'b0 : 1'b1;
  endtask

  // One ser_clk period of 10 clk_in cycles: din settles 2 cycles before the rise.
  task automatic send_bit(input bit b);
    @(negedge clk_in);
    rx_if.ser_din = b;
    repeat (2) @(negedge clk_in);
    rx_if.ser_clk = 1'b1;
    repeat (5) @(negedge clk_in);
    rx_if.ser_clk = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic send_bits(input int n, input logic [7:0] pat);
    for (int i = 0; i < n; i++) send_bit(pat[7 - (i % 8)]);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fv0, n;
    rx_if.ser_clk = 1'b0;
    rx_if.ser_din = 1'b0;
    rx_if.ser_syn = 1'b1;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("reset_data_zero", longint'(rx_if.data_reg == '0), 1);
    chk("reset_frame_cnt", rx_if.frame_cnt, 0);
    chk("reset_busy", rx_if.busy, 0);

    // Good frame of 0xA5 repeated
    fv0 = fv_seen;
    syn_set(1'b1); idle(2);
    send_bits(N, 8'hA5);
    syn_set(1'b0); idle(6);
    chk("good_fv_pulses", fv_seen - fv0, 1);
    chk("good_data_top", rx_if.data_reg[619:612], 8'hA5);
    chk("good_data_mid", rx_if.data_reg[11:4], 8'hA5);
    chk("good_data_low", rx_if.data_reg[3:0], 4'hA);
    chk("good_frame_cnt", rx_if.frame_cnt, 1);
    chk("good_no_err", rx_if.err_short + rx_if.err_long + rx_if.err_timeout, 0);

    // Short frame: 619 bits
    fv0 = fv_seen;
    syn_set(1'b1); idle(2);
    send_bits(N - 1, 8'h0F);
    syn_set(1'b0); idle(6);
    chk("short_err", rx_if.err_short, 1);
    chk("short_bit_cnt", rx_if.bit_cnt, 619);
    chk("short_data_kept", rx_if.data_reg[11:4], 8'hA5);
    chk("short_no_fv", fv_seen - fv0, 0);

    // Long frame: 621 bits; start of frame must clear the sticky short flag
    fv0 = fv_seen;
    syn_set(1'b1); idle(4);
    chk("long_start_clears_short", rx_if.err_short, 0);
    chk("long_start_busy", rx_if.busy, 1);
    send_bits(N + 1, 8'hFF);
    idle(2);
    chk("long_err", rx_if.err_long, 1);
    chk("long_busy_wait_end", rx_if.busy, 1);
    syn_set(1'b0); idle(6);
    chk("long_busy_after", rx_if.busy, 0);
    chk("long_no_fv", fv_seen - fv0, 0);
    chk("long_bit_cnt", rx_if.bit_cnt, 620);
    chk("long_frame_cnt", rx_if.frame_cnt, 1);

    // Timeout: 5 edges, then ser_clk held high
    syn_set(1'b1); idle(2);
    send_bits(4, 8'hA5);
    @(negedge clk_in);
    rx_if.ser_din = 1'b1;
    repeat (2) @(negedge clk_in);
    rx_if.ser_clk = 1'b1;
    n = 0;
    while (!rx_if.err_timeout && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    chk("timeout_latency", n, 103);
    chk("timeout_busy", rx_if.busy, 1);
    chk("timeout_bit_cnt", rx_if.bit_cnt, 5);
    rx_if.ser_clk = 1'b0;
    idle(20);
    chk("timeout_waits_for_syn", rx_if.busy, 1);
    syn_set(1'b0); idle(6);
    chk("timeout_idle", rx_if.busy, 0);
    chk("timeout_sticky", rx_if.err_timeout, 1);

    // Reset in the middle of a frame
    syn_set(1'b1); idle(2);
    send_bits(300, 8'hC3);
    @(negedge clk_in);
    rst = 1'b1;
    rx_if.ser_syn = 1'b1;
    rx_if.ser_clk = 1'b0;
    @(negedge clk_in);
    rst = 1'b0;
    chk("rst_data_zero", longint'(rx_if.data_reg == '0), 1);
    chk("rst_frame_cnt", rx_if.frame_cnt, 0);
    chk("rst_busy", rx_if.busy, 0);
    chk("rst_bit_cnt", rx_if.bit_cnt, 0);
    chk("rst_err_timeout", rx_if.err_timeout, 0);
    idle(3);

    // First of two consecutive good frames
    fv0 = fv_seen;
    syn_set(1'b1); idle(2);
    send_bits(N, 8'h3C);
    syn_set(1'b0); idle(6);
    chk("rst_frame_fv", fv_seen - fv0, 1);
    chk("rst_frame_cnt1", rx_if.frame_cnt, 1);
    chk("rst_frame_data_top", rx_if.data_reg[619:612], 8'h3C);
    chk("rst_frame_data_mid", rx_if.data_reg[11:4], 8'h3C);

    // Second good frame: 620th rise coincides with syn deassertion
    fv0 = fv_seen;
    syn_set(1'b1); idle(2);
    send_bits(N - 1, 8'h5A);
    @(negedge clk_in);
    rx_if.ser_din = 1'b1;
    repeat (2) @(negedge clk_in);
    rx_if.ser_clk = 1'b1;
    rx_if.ser_syn = 1'b1;
    repeat (5) @(negedge clk_in);
    rx_if.ser_clk = 1'b0;
    idle(5);
    chk("edge_syn_fv", fv_seen - fv0, 1);
    chk("edge_syn_frame_cnt", rx_if.frame_cnt, 2);
    chk("edge_syn_no_err", rx_if.err_short + rx_if.err_long + rx_if.err_timeout, 0);
    chk("edge_syn_data_mid", rx_if.data_reg[11:4], 8'h5A);
    chk("edge_syn_data_low", rx_if.data_reg[3:0], 4'h5);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
